mem_port_arbiter: RTL and testbench

Shares the CPU's single-ported memory between instruction fetch (IF) and the MEM-stage data access (DM). It holds each grant for the full fixed memory latency and returns read data with a one-cycle acknowledge pulse. DM has priority by default; an optional fairness counter bounds IF starvation. It sits between the pipeline's fetch/memory stages and the memory macro.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_arb_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Owner encoding of the latched grant
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Wait counter width; LAT must fit (1..15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the memory macro.
// slave  : the arbiter's view (takes requests, drives the memory)
// master : the environment's view (requesters and memory)
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational owner selection: DM wins unless the fairness force bit
// hands the slot to a waiting IF. A port whose own ack is in progress is
// masked so a lingering req is not mistaken for a fresh request.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic if_mask,
  input  logic dm_mask,
  input  logic force_if,
  output logic grant_valid,
  output logic grant_owner
);

  logic if_ok;
  logic dm_ok;

  assign if_ok = if_req & ~if_mask;
  assign dm_ok = dm_req & ~dm_mask;

  // Pick the owner from the eligible requests
  always_comb begin
    grant_valid = if_ok | dm_ok;
    grant_owner = OWN_IF;
    if (dm_ok && !(force_if && if_ok)) begin
      grant_owner = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Each grant owns the memory for IDLE -> ISSUE -> WAIT(LAT) -> DONE, and the
// owner receives a one-cycle ack with the captured read data.
// Optional fairness (bounded IF starvation) is enabled by defining ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT);

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic             we_reg, we_next;
  logic [DW-1:0]    wdata_reg, wdata_next;
  logic [DW-1:0]    rdata_reg, rdata_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic grant_valid;
  logic grant_owner;
  logic if_mask;
  logic dm_mask;
  logic force_if;

  // A port is ineligible during its own ack cycle
  assign if_mask = (state_reg == ST_DONE) && (owner_reg == OWN_IF);
  assign dm_mask = (state_reg == ST_DONE) && (owner_reg == OWN_DM);

  arb_pick u_pick (
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .if_mask     (if_mask),
    .dm_mask     (dm_mask),
    .force_if    (force_if),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_reg, starve_next;

  // Count DM grants taken while IF waits; any IF grant or idle IF clears it
  always_comb begin
    starve_next = starve_reg;
    if (state_reg == ST_IDLE) begin
      if (!bus.if_req) begin
        starve_next = '0;
      end else if (grant_valid) begin
        starve_next = (grant_owner == OWN_IF) ? '0 : starve_reg + SW'(1);
      end
    end
  end

  // Starve counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end

  assign force_if = (starve_reg == SW'(STARVE_MAX));
`else
  // Strict DM priority: STARVE_MAX has no effect, the force bit stays low
  assign force_if = 1'b0 & (STARVE_MAX > 0);
`endif

  // Next-state and datapath latch logic
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_next = grant_owner;
          if (grant_owner == OWN_DM) begin
            addr_next  = bus.dm_addr;
            we_next    = bus.dm_we;
            wdata_next = bus.dm_wdata;
          end else begin
            addr_next  = bus.if_addr;
            we_next    = 1'b0;
            wdata_next = '0;
          end
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = LAT_LOAD;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_reg == CNT_W'(1)) begin
          rdata_next = we_reg ? '0 : bus.mem_rdata;
          cnt_next   = '0;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and latch registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_IF;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs decoded from registered state; memory bus is quiet outside ISSUE
  always_comb begin
    bus.mem_en    = (state_reg == ST_ISSUE);
    bus.mem_we    = (state_reg == ST_ISSUE) && (owner_reg == OWN_DM) && we_reg;
    bus.mem_addr  = (state_reg == ST_ISSUE) ? addr_reg : '0;
    bus.mem_wdata = (state_reg == ST_ISSUE) ? wdata_reg : '0;
    bus.if_ack    = (state_reg == ST_DONE) && (owner_reg == OWN_IF);
    bus.dm_ack    = (state_reg == ST_DONE) && (owner_reg == OWN_DM);
    bus.if_rdata  = bus.if_ack ? rdata_reg : '0;
    bus.dm_rdata  = bus.dm_ack ? rdata_reg : '0;
    bus.busy      = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions,
// plus hand-written sequences for contention, starvation/fairness and reset.
// Per-port scoreboards hold expected read data until the matching ack.
module tb_mem_port_arbiter;
  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int LAT        = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0;

  logic [DW-1:0] q_if[$];
  logic [DW-1:0] q_dm[$];
  logic [DW-1:0] mon_e;

  typedef struct {
    bit            dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            hold;
    logic [DW-1:0] exp_rdata;
    bit            exp_we;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h3C5A);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory model: data valid only in the cycle LAT after mem_en
  logic [DW-1:0] pend_data = '0;
  int            pend_cnt  = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      pend_data <= bus.mem_we ? 16'hFFFF : model_rd(bus.mem_addr);
      pend_cnt  <= LAT;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign bus.mem_rdata = (pend_cnt == 1) ? pend_data : 16'hDEAD;

  // Scoreboard and per-cycle bus rules
  always @(negedge clk) begin
    if (bus.mem_en) en_count++;
    if (bus.if_ack) begin
      if (q_if.size() == 0) chk("if_ack_unexpected", 1, 0);
      else begin
        mon_e = q_if.pop_front();
        chk("if_rdata", bus.if_rdata, mon_e);
        $display("ack IF  rdata=%h cycle=%0d", bus.if_rdata, cyc);
      end
    end
    if (bus.dm_ack) begin
      if (q_dm.size() == 0) chk("dm_ack_unexpected", 1, 0);
      else begin
        mon_e = q_dm.pop_front();
        chk("dm_rdata", bus.dm_rdata, mon_e);
        $display("ack DM  rdata=%h cycle=%0d", bus.dm_rdata, cyc);
      end
    end
    chk("ack_exclusive", bus.if_ack & bus.dm_ack, 0);
    if (!bus.mem_en) chk("mem_idle_zero", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    if (!bus.if_ack) chk("if_rdata_idle", bus.if_rdata, 0);
    if (!bus.dm_ack) chk("dm_rdata_idle", bus.dm_rdata, 0);
  end

  task automatic wait_ack(input bit dm, input int limit, output int n, output bit seen);
    n = 0;
    seen = 0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      seen = dm ? bus.dm_ack : bus.if_ack;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    bit seen;
    int en0;
    @(negedge clk);
    en0 = en_count;
    if (v.dm) begin
      q_dm.push_back(v.exp_rdata);
      bus.dm_req = 1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
    end else begin
      q_if.push_back(v.exp_rdata);
      bus.if_req = 1; bus.if_addr = v.addr;
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_issue_en", idx), bus.mem_en, 1);
    chk($sformatf("v%0d_issue_addr", idx), bus.mem_addr, v.addr);
    chk($sformatf("v%0d_issue_we", idx), bus.mem_we, v.exp_we);
    if (v.exp_we) chk($sformatf("v%0d_issue_wdata", idx), bus.mem_wdata, v.wdata);
    chk($sformatf("v%0d_busy", idx), bus.busy, 1);
    wait_ack(v.dm, 20, n, seen);
    chk($sformatf("v%0d_ack_seen", idx), seen, 1);
    chk($sformatf("v%0d_latency", idx), n + 1, LAT + 2);
    if (v.hold) @(negedge clk);
    bus.if_req = 0;
    bus.dm_req = 0;
    bus.dm_we  = 0;
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_single_mem_en", idx), en_count - en0, 1);
    $display("vec %0d port=%s we=%0d addr=%h latency=%0d", idx, v.dm ? "DM" : "IF", v.we, v.addr, n + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, d_at, i_at, en0, dm_before;
    bit seen, if_done, stop, finished, if_by_50;

    vecs[0] = '{dm:0, we:0, addr:16'h0010, wdata:16'h0000, hold:0, exp_rdata:16'hBEEF, exp_we:0};
    vecs[1] = '{dm:1, we:1, addr:16'h0020, wdata:16'h1234, hold:0, exp_rdata:16'h0000, exp_we:1};
    vecs[2] = '{dm:1, we:0, addr:16'h0030, wdata:16'h0000, hold:0, exp_rdata:16'h3C6A, exp_we:0};
    vecs[3] = '{dm:0, we:0, addr:16'hFFFF, wdata:16'h0000, hold:0, exp_rdata:16'hC3A5, exp_we:0};
    vecs[4] = '{dm:1, we:0, addr:16'h0000, wdata:16'h0000, hold:0, exp_rdata:16'h3C5A, exp_we:0};
    vecs[5] = '{dm:1, we:1, addr:16'hFFFF, wdata:16'hFFFF, hold:0, exp_rdata:16'h0000, exp_we:1};
    vecs[6] = '{dm:0, we:0, addr:16'h1234, wdata:16'h0000, hold:1, exp_rdata:16'h2E6E, exp_we:0};
    vecs[7] = '{dm:1, we:0, addr:16'h00A5, wdata:16'h0000, hold:1, exp_rdata:16'h3CFF, exp_we:0};

    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus.busy, bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack}, 0);
    chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata}, 0);
    rst = 0;
    @(negedge clk);
    chk("post_reset_idle", bus.busy, 0);

    // Table of single transactions
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both ports request together: DM first, IF one full slot later
    @(negedge clk);
    q_dm.push_back(model_rd(16'h0050));
    q_if.push_back(model_rd(16'h0060));
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0050;
    bus.if_req = 1; bus.if_addr = 16'h0060;
    @(posedge clk);
    @(negedge clk);
    chk("both_first_addr", bus.mem_addr, 16'h0050);
    d_at = -1; i_at = -1;
    for (int k = 1; k <= 40 && (d_at < 0 || i_at < 0); k++) begin
      @(negedge clk);
      if (bus.dm_ack) begin bus.dm_req = 0; d_at = k; end
      if (bus.if_ack) begin bus.if_req = 0; i_at = k; end
    end
    chk("both_done", {d_at >= 0, i_at >= 0}, 2'b11);
    chk("if_after_dm_gap", i_at - d_at, LAT + 3);
    $display("contention dm_ack=%0d if_ack=%0d", d_at, i_at);
    repeat (2) @(negedge clk);

    // Continuous DM reads with IF pending
    @(negedge clk);
    q_dm.push_back(model_rd(16'h0044));
    q_if.push_back(model_rd(16'h0088));
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0044;
    bus.if_req = 1; bus.if_addr = 16'h0088;
    dm_before = 0; if_done = 0; stop = 0; finished = 0; if_by_50 = 0;
    for (c = 1; c <= 300 && !finished; c++) begin
      @(negedge clk);
      if (bus.if_ack) begin
        bus.if_req = 0; if_done = 1;
        if (c <= 50) if_by_50 = 1;
      end
      if (bus.dm_ack) begin
        if (!if_done) dm_before++;
        if (stop) bus.dm_req = 0;
        else q_dm.push_back(model_rd(16'h0044));
      end
`ifdef ARB_FAIR_EN
      if (if_done) stop = 1;
`else
      if (c == 50) stop = 1;
`endif
      finished = stop && !bus.dm_req && if_done;
    end
    chk("starve_seq_done", finished, 1);
`ifdef ARB_FAIR_EN
    chk("fair_dm_acks_before_if", dm_before, STARVE_MAX);
`else
    chk("strict_no_if_ack_50", if_by_50, 0);
`endif
    $display("starvation dm_acks_before_if=%0d if_ack_within_50=%0d", dm_before, if_by_50);
    repeat (2) @(negedge clk);

    // Reset pulsed during WAIT, req held throughout
    @(negedge clk);
    q_if.push_back(model_rd(16'h0070));
    bus.if_req = 1; bus.if_addr = 16'h0070;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", bus.busy, 1);
    rst = 1;
    #1;
    chk("rst_async_ctrl", {bus.busy, bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack}, 0);
    chk("rst_async_data", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_quiet", bus.if_ack | bus.dm_ack | bus.mem_en, 0);
    end
    rst = 0;
    en0 = en_count;
    wait_ack(0, 20, n, seen);
    chk("rst_reserve_seen", seen, 1);
    chk("rst_reserve_latency", n, LAT + 2);
    bus.if_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_reserve_single_en", en_count - en0, 1);
    $display("reset reserve latency=%0d", n);

    chk("scoreboard_drained", q_if.size() + q_dm.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
